// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with parity/framing error flags and break recovery
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] MID       = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   state_t               state;
   state_t               next_state;
   logic                 sync_1;
   logic                 line;
   logic [CNT_W-1:0]     clk_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 par_acc;
   logic                 par_err;
   logic                 frm_err;
   logic                 mid_tick;
   logic                 bit_tick;
   logic                 last_data;
   logic                 last_stop;
   logic                 busy_next;
   logic                 frame_done;

   assign mid_tick  = (clk_cnt == MID);
   assign bit_tick  = (clk_cnt == LAST_CNT);
   assign last_data = (bit_idx == LAST_DATA);
   assign last_stop = (bit_idx == LAST_STOP);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync_1 <= 1'b1;
         line   <= 1'b1;
      end else begin
         sync_1 <= i_Rx_Serial;
         line   <= sync_1;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) state <= S_IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (!line) next_state = S_START;
         S_START:     if (mid_tick) next_state = line ? S_IDLE : S_DATA;
         S_DATA:      if (bit_tick && last_data) next_state = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY:    if (bit_tick) next_state = S_STOP;
         // A low final stop bit means the line may be in break; wait for it to rise
         S_STOP:      if (bit_tick && last_stop) next_state = line ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (line) next_state = S_IDLE;
         default:     next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy_next  = (next_state != S_IDLE);
      frame_done = (state == S_STOP) && bit_tick && last_stop;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         clk_cnt      <= '0;
         bit_idx      <= '0;
         rx_shift     <= '0;
         par_acc      <= 1'b0;
         par_err      <= 1'b0;
         frm_err      <= 1'b0;
         o_Rx_DV      <= 1'b0;
         o_Rx_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Busy       <= 1'b0;
      end else begin
         o_Rx_DV <= 1'b0;
         o_Busy  <= busy_next;
         case (state)
            S_START: begin
               clk_cnt <= mid_tick ? '0 : clk_cnt + 1'b1;
            end
            S_DATA: begin
               clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
               if (bit_tick) begin
                  // LSB arrives first, so shifting in from the top leaves it in bit 0
                  rx_shift <= {line, rx_shift[DATA_BITS-1:1]};
                  par_acc  <= par_acc ^ line;
                  bit_idx  <= last_data ? '0 : bit_idx + 1'b1;
               end
            end
            S_PARITY: begin
               clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
               if (bit_tick) par_err <= (PARITY == 1) ? ~(par_acc ^ line) : (par_acc ^ line);
            end
            S_STOP: begin
               clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
               if (bit_tick) begin
                  bit_idx <= bit_idx + 1'b1;
                  frm_err <= frm_err | ~line;
               end
               if (frame_done) begin
                  o_Rx_DV      <= 1'b1;
                  o_Rx_Byte    <= rx_shift;
                  o_Parity_Err <= par_err;
                  o_Frame_Err  <= frm_err | ~line;
               end
            end
            default: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               par_acc <= 1'b0;
               par_err <= 1'b0;
               frm_err <= 1'b0;
            end
         endcase
      end
   end

endmodule
